// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported memory between instruction fetch and data access.
// Data wins ties unless fetch has been starved; a watchdog aborts stuck transactions.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    // Fetch port
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    // Data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    // Memory port
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    // Pipeline control
    output logic              stall_if,
    output logic              stall_mem,
    output logic              timeout_err
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StResp = 2'b10
    } state_e;

    state_e state_q, state_d;

    logic              owner_data_q, owner_data_d;
    logic [3:0]        starve_q, starve_d;
    logic [7:0]        wd_q, wd_d;

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic              if_ack_q, if_ack_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_ack_q, d_ack_d;
    logic              timeout_err_q, timeout_err_d;

    logic              grant_data;
    logic              complete;
    logic              abort;
    logic [DATA_W-1:0] resp_data;

    // Grant decision, only meaningful in IDLE.
    always_comb begin
        grant_data = 1'b0;
        if (d_req && (!if_req || (starve_q != StarveMax))) begin
            grant_data = 1'b1;
        end
    end

    // Completion decision, only meaningful in BUSY; mem_ready wins over the watchdog.
    always_comb begin
        complete = 1'b0;
        abort    = 1'b0;
        if (mem_ready) begin
            complete = 1'b1;
        end else if (wd_q == TimeoutLast) begin
            complete = 1'b1;
            abort    = 1'b1;
        end
    end

    // Stores and aborted transactions return zero.
    always_comb begin
        resp_data = mem_rdata;
        if (abort || (owner_data_q && mem_we_q)) begin
            resp_data = '0;
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_data_d  = owner_data_q;
        starve_d      = starve_q;
        wd_d          = wd_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_rdata_d    = if_rdata_q;
        if_ack_d      = 1'b0;
        d_rdata_d     = d_rdata_q;
        d_ack_d       = 1'b0;
        timeout_err_d = timeout_err_q;

        unique case (state_q)
            StIdle: begin
                if (d_req || if_req) begin
                    owner_data_d = grant_data;
                    mem_req_d    = 1'b1;
                    wd_d         = '0;
                    state_d      = StBusy;
                    if (grant_data) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        if (if_req && (starve_q != StarveMax)) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        starve_d    = '0;
                    end
                end
            end

            StBusy: begin
                if (complete) begin
                    mem_req_d = 1'b0;
                    wd_d      = '0;
                    state_d   = StResp;
                    if (owner_data_q) begin
                        d_rdata_d = resp_data;
                        d_ack_d   = 1'b1;
                    end else begin
                        if_rdata_d = resp_data;
                        if_ack_d   = 1'b1;
                    end
                    if (abort) begin
                        timeout_err_d = 1'b1;
                    end
                end else begin
                    wd_d = wd_q + 8'd1;
                end
            end

            StResp: begin
                state_d = StIdle;
            end

            default: begin
                state_d   = StIdle;
                mem_req_d = 1'b0;
                wd_d      = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            owner_data_q  <= 1'b0;
            starve_q      <= '0;
            wd_q          <= '0;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_rdata_q    <= '0;
            if_ack_q      <= 1'b0;
            d_rdata_q     <= '0;
            d_ack_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_data_q  <= owner_data_d;
            starve_q      <= starve_d;
            wd_q          <= wd_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_rdata_q    <= if_rdata_d;
            if_ack_q      <= if_ack_d;
            d_rdata_q     <= d_rdata_d;
            d_ack_q       <= d_ack_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_rdata    = if_rdata_q;
    assign if_ack      = if_ack_q;
    assign d_rdata     = d_rdata_q;
    assign d_ack       = d_ack_q;
    assign timeout_err = timeout_err_q;

    // Stall releases in the RESP cycle so the stage advances with the ack.
    assign stall_if  = if_req & ~if_ack_q;
    assign stall_mem = d_req & ~d_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Cycle 0 is the cycle in which a request is first driven; checks run 1-2 time units after edges.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        stall_if;
    logic        stall_mem;
    logic        timeout_err;

    logic        zero_wait;
    logic        ready_man;
    logic [31:0] rdata_man;

    int errors = 0;
    int checks = 0;

    // Zero-wait memory answers addr + 0x10000000 whenever a request is up.
    assign mem_ready = zero_wait ? mem_req : ready_man;
    assign mem_rdata = zero_wait ? (mem_addr + 32'h1000_0000) : rdata_man;

    mem_port_arbiter #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .STARVE_MAX(4),
        .TIMEOUT   (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_rdata   (if_rdata),
        .if_ack     (if_ack),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_ack      (d_ack),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .stall_if   (stall_if),
        .stall_mem  (stall_mem),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1; if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_wdata = '0; zero_wait = 1'b0; ready_man = 1'b0; rdata_man = '0;
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_we, if_ack, d_ack, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b, want 00000",
                     {mem_req, mem_we, if_ack, d_ack, timeout_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, d_rdata} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h, want all 0",
                     mem_addr, mem_wdata, if_rdata, d_rdata);
        end
        checks++;
        if ({stall_if, stall_mem} !== 2'b00) begin
            errors++;
            $display("FAIL reset_stall: got %b, want 00", {stall_if, stall_mem});
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (mem_req !== 1'b0) begin
                errors++;
                $display("FAIL idle_mem_req cycle %0d: got %b, want 0", c, mem_req);
            end
        end
    endtask

    task automatic test_single_fetch();
        if_req = 1'b1;
        if_addr = 32'h0000_0040;
        rdata_man = 32'h8C22_0004;
        #1;
        checks++;
        if (stall_if !== 1'b1) begin
            errors++;
            $display("FAIL fetch_stall c0: got %b, want 1", stall_if);
        end
        for (int c = 1; c <= 4; c++) begin
            tick();
            ready_man = (c == 3);
            #1;
            if (c == 1) begin
                checks++;
                if ({mem_req, mem_we, mem_addr} !== {2'b10, 32'h0000_0040}) begin
                    errors++;
                    $display("FAIL fetch_mem c1: got req=%b we=%b addr=%h, want 1 0 00000040",
                             mem_req, mem_we, mem_addr);
                end
            end
            if (c < 4) begin
                checks++;
                if ({stall_if, if_ack} !== 2'b10) begin
                    errors++;
                    $display("FAIL fetch_wait c%0d: got stall=%b ack=%b, want 1 0",
                             c, stall_if, if_ack);
                end
            end else begin
                checks++;
                if ({if_ack, stall_if, if_rdata} !== {2'b10, 32'h8C22_0004}) begin
                    errors++;
                    $display("FAIL fetch_ack c4: got ack=%b stall=%b rdata=%h, want 1 0 8c220004",
                             if_ack, stall_if, if_rdata);
                end
            end
        end
        if_req = 1'b0;
        ready_man = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_simultaneous();
        zero_wait = 1'b1;
        if_req = 1'b1; if_addr = 32'h0000_0044;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0100;
        for (int c = 1; c <= 5; c++) begin
            tick();
            #1;
            if (c <= 4) begin
                checks++;
                if (stall_if !== 1'b1) begin
                    errors++;
                    $display("FAIL sim_stall_if c%0d: got %b, want 1", c, stall_if);
                end
            end
            if (c == 2) begin
                checks++;
                if ({d_ack, if_ack, d_rdata} !== {2'b10, 32'h1000_0100}) begin
                    errors++;
                    $display("FAIL sim_d_ack c2: got d_ack=%b if_ack=%b rdata=%h, want 1 0 10000100",
                             d_ack, if_ack, d_rdata);
                end
                d_req = 1'b0;
            end
            if (c == 5) begin
                checks++;
                if ({if_ack, if_rdata} !== {1'b1, 32'h1000_0044}) begin
                    errors++;
                    $display("FAIL sim_if_ack c5: got ack=%b rdata=%h, want 1 10000044",
                             if_ack, if_rdata);
                end
                if_req = 1'b0;
            end
        end
        tick();
        tick();
    endtask

    task automatic test_starvation();
        logic [5:0] grants;
        logic [5:0] want;
        int         n;
        want = 6'b101111; // bit i = 1 means grant i went to data
        grants = '0;
        n = 0;
        if_req = 1'b1; if_addr = 32'h0000_0080;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        for (int c = 0; c < 40 && n < 6; c++) begin
            tick();
            if (mem_req === 1'b1) begin
                grants[n] = (mem_addr === 32'h0000_0300);
                n++;
            end
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL starve_count: got %0d grants, want 6", n);
        end
        checks++;
        if (grants !== want) begin
            errors++;
            $display("FAIL starve_order: got %b, want %b", grants, want);
        end
        tick();
        if_req = 1'b0;
        d_req = 1'b0;
        tick();
        tick();
        zero_wait = 1'b0;
    endtask

    task automatic test_store_timeout();
        ready_man = 1'b0;
        rdata_man = 32'h1234_5678;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_wdata} !==
                    {2'b11, 32'h0000_0200, 32'hDEAD_BEEF}) begin
                    errors++;
                    $display("FAIL store_mem c1: got req=%b we=%b addr=%h wdata=%h",
                             mem_req, mem_we, mem_addr, mem_wdata);
                end
            end
            if (c == 15) begin
                checks++;
                if ({mem_req, d_ack, timeout_err} !== 3'b100) begin
                    errors++;
                    $display("FAIL timeout_early c15: got req=%b ack=%b err=%b, want 1 0 0",
                             mem_req, d_ack, timeout_err);
                end
            end
            if (c == 16) begin
                checks++;
                if ({d_ack, timeout_err, mem_req, d_rdata} !== {3'b110, 32'h0}) begin
                    errors++;
                    $display("FAIL timeout_ack c16: got ack=%b err=%b req=%b rdata=%h",
                             d_ack, timeout_err, mem_req, d_rdata);
                end
                d_req = 1'b0;
                d_we = 1'b0;
            end
        end
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if ({timeout_err, d_ack} !== 2'b10) begin
            errors++;
            $display("FAIL timeout_sticky: got err=%b ack=%b, want 1 0", timeout_err, d_ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: got %b, want 0", timeout_err);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_busy();
        ready_man = 1'b0;
        if_req = 1'b1;
        if_addr = 32'h0000_0060;
        tick();
        tick();
        checks++;
        if (mem_req !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy: got mem_req=%b, want 1", mem_req);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({mem_req, if_ack} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_drop: got req=%b ack=%b, want 0 0", mem_req, if_ack);
        end
        tick();
        checks++;
        if ({mem_req, if_ack} !== 2'b00) begin
            errors++;
            $display("FAIL midrst_hold: got req=%b ack=%b, want 0 0", mem_req, if_ack);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_addr, if_ack} !== {1'b1, 32'h0000_0060, 1'b0}) begin
            errors++;
            $display("FAIL midrst_regrant: got req=%b addr=%h ack=%b, want 1 00000060 0",
                     mem_req, mem_addr, if_ack);
        end
        ready_man = 1'b1;
        rdata_man = 32'hCAFE_0001;
        tick();
        ready_man = 1'b0;
        checks++;
        if ({if_ack, if_rdata} !== {1'b1, 32'hCAFE_0001}) begin
            errors++;
            $display("FAIL midrst_ack: got ack=%b rdata=%h, want 1 cafe0001", if_ack, if_rdata);
        end
        if_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_starvation();
        test_store_timeout();
        test_reset_mid_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
